// File: rtl/keypad_encoder.sv
// 4x3 keypad scanner: drives rows, synchronizes and debounces the columns, and
// emits one 4-bit key code plus a one-cycle strobe per accepted press.
`timescale 1ns/1ps
module keypad_encoder #(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       CLK,
    input  logic       RST,
    output logic [3:0] ROW_OUT,
    input  logic [2:0] COL_IN,
    output logic [3:0] BCD_output,
    output logic       KEY_VALID,
    output logic       KEY_HELD
);
    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [3:0]        CODE_NONE = 4'b1111;
    localparam logic [11:0]       STAR_HASH = 12'b1010_0000_0000;

    typedef enum logic {S_IDLE, S_PRESSED} state_t;

    logic [2:0]        col_s1_q, col_s2_q;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [1:0]        row_q, row_d;
    logic [11:0]       snap_q, snap_d;
    logic [11:0]       prev_snap_q, prev_snap_d;
    logic [11:0]       deb_keys_q, deb_keys_d;
    logic [CNT_W-1:0]  stable_cnt_q, stable_cnt_d;
    logic [11:0]       scan_snap;
    logic [3:0]        enc;
    state_t            state_q, state_d;
    logic [3:0]        bcd_q, bcd_d;
    logic              valid_q, valid_d;
    logic              held_q, held_d;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_row
            assign ROW_OUT[gi] = (row_q != 2'(gi));
        end
    endgenerate

    // Snapshot bits are 1 = pressed; index = row*3 + column.
    always_comb begin
        slot_d       = slot_q + SLOT_W'(1);
        row_d        = row_q;
        snap_d       = snap_q;
        prev_snap_d  = prev_snap_q;
        stable_cnt_d = stable_cnt_q;
        deb_keys_d   = deb_keys_q;
        scan_snap    = snap_q;
        scan_snap[3*int'(row_q) +: 3] = ~col_s2_q;
        if (slot_q == SLOT_LAST) begin
            slot_d = '0;
            row_d  = row_q + 2'd1;
            snap_d = scan_snap;
            if (row_q == 2'd3) begin
                prev_snap_d = scan_snap;
                if (scan_snap == prev_snap_q) begin
                    if (stable_cnt_q != CNT_MAX)
                        stable_cnt_d = stable_cnt_q + CNT_W'(1);
                end else begin
                    stable_cnt_d = '0;
                end
                if (stable_cnt_d == CNT_MAX)
                    deb_keys_d = scan_snap;
            end
        end
    end

    function automatic logic [3:0] key_code(input logic [3:0] idx);
        case (idx)
            4'd9:    key_code = 4'd11;
            4'd10:   key_code = 4'd0;
            4'd11:   key_code = 4'd12;
            default: key_code = idx + 4'd1;
        endcase
    endfunction

    always_comb begin
        enc = CODE_NONE;
        if (deb_keys_q == STAR_HASH) begin
            enc = 4'd13;
        end else if ($countones(deb_keys_q) == 1) begin
            for (int i = 0; i < 12; i++)
                if (deb_keys_q[i]) enc = key_code(4'(i));
        end
    end

    // Only an all-released debounced state ends a press; other multi-key
    // patterns leave the held code untouched.
    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        valid_d = 1'b0;
        held_d  = held_q;
        case (state_q)
            S_IDLE: begin
                if (enc != CODE_NONE) begin
                    bcd_d   = enc;
                    valid_d = 1'b1;
                    held_d  = 1'b1;
                    state_d = S_PRESSED;
                end
            end
            S_PRESSED: begin
                if (deb_keys_q == '0) begin
                    bcd_d   = CODE_NONE;
                    held_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            col_s1_q     <= 3'b111;
            col_s2_q     <= 3'b111;
            slot_q       <= '0;
            row_q        <= '0;
            snap_q       <= '0;
            prev_snap_q  <= '0;
            deb_keys_q   <= '0;
            stable_cnt_q <= '0;
            state_q      <= S_IDLE;
            bcd_q        <= CODE_NONE;
            valid_q      <= 1'b0;
            held_q       <= 1'b0;
        end else begin
            col_s1_q     <= COL_IN;
            col_s2_q     <= col_s1_q;
            slot_q       <= slot_d;
            row_q        <= row_d;
            snap_q       <= snap_d;
            prev_snap_q  <= prev_snap_d;
            deb_keys_q   <= deb_keys_d;
            stable_cnt_q <= stable_cnt_d;
            state_q      <= state_d;
            bcd_q        <= bcd_d;
            valid_q      <= valid_d;
            held_q       <= held_d;
        end
    end

    assign BCD_output = bcd_q;
    assign KEY_VALID  = valid_q;
    assign KEY_HELD   = held_q;
endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder: a keypad model answers the row drive, and
// expected codes and pulse cycles are hand-computed for SCAN_DIV=4, DEBOUNCE_SCANS=3.
`timescale 1ns/1ps
module tb_keypad_encoder;
    localparam logic [11:0] K5    = 12'h010;
    localparam logic [11:0] K0    = 12'h400;
    localparam logic [11:0] K9    = 12'h100;
    localparam logic [11:0] KSTAR = 12'h200;
    localparam logic [11:0] KHASH = 12'h800;
    localparam logic [11:0] K12   = 12'h003;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] ROW_OUT;
    logic [2:0] COL_IN;
    logic [3:0] BCD_output;
    logic       KEY_VALID;
    logic       KEY_HELD;
    logic [11:0] keys = '0;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int last_pulse_cyc = -1;
    int base = 0;
    int p0 = 0;
    logic [3:0] last_pulse_code = 4'hF;

    always #5 CLK = ~CLK;

    keypad_encoder #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .CLK(CLK), .RST(RST), .ROW_OUT(ROW_OUT), .COL_IN(COL_IN),
        .BCD_output(BCD_output), .KEY_VALID(KEY_VALID), .KEY_HELD(KEY_HELD)
    );

    // A pressed key shorts its column to the driven (low) row.
    always_comb begin
        COL_IN = 3'b111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (keys[r*3+c] && !ROW_OUT[r]) COL_IN[c] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        if (KEY_VALID === 1'b1) begin
            pulse_cnt++;
            last_pulse_cyc = cyc;
            last_pulse_code = BCD_output;
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic align();
        while (cyc % 16 != 0) tick();
    endtask

    initial begin
        // 1. reset and row sequencing
        ticks(3);
        check("rst_row", ROW_OUT, 4'b1110);
        check("rst_bcd", BCD_output, 4'b1111);
        check("rst_valid", KEY_VALID, 0);
        check("rst_held", KEY_HELD, 0);
        RST = 1'b0;
        cyc = 0;
        ticks(3);
        check("row0_last", ROW_OUT, 4'b1110);
        tick();
        check("row1", ROW_OUT, 4'b1101);
        ticks(4);
        check("row2", ROW_OUT, 4'b1011);
        ticks(4);
        check("row3", ROW_OUT, 4'b0111);
        ticks(4);
        check("row_wrap", ROW_OUT, 4'b1110);

        // 2. single press of key 5 with exact latency
        align();
        base = cyc; p0 = pulse_cnt; keys = K5;
        ticks(64);
        check("k5_no_early_pulse", pulse_cnt - p0, 0);
        tick();
        check("k5_pulse_cycle", last_pulse_cyc - base, 65);
        check("k5_code", BCD_output, 5);
        check("k5_held", KEY_HELD, 1);
        ticks(160 - 65);
        check("k5_one_pulse", pulse_cnt - p0, 1);
        check("k5_code_hold", BCD_output, 5);
        base = cyc; keys = '0;
        ticks(64);
        check("k5_rel_still_held", KEY_HELD, 1);
        tick();
        check("k5_rel_bcd", BCD_output, 4'b1111);
        check("k5_rel_held", KEY_HELD, 0);

        // 3. key 0 pressed twice
        for (int n = 0; n < 2; n++) begin
            align();
            p0 = pulse_cnt; keys = K0;
            ticks(128);
            check("k0_pulse", pulse_cnt - p0, 1);
            check("k0_code", last_pulse_code, 0);
            check("k0_bcd", BCD_output, 0);
            keys = '0;
            ticks(128);
            check("k0_rel_bcd", BCD_output, 4'b1111);
        end

        // two ordinary keys together: not a code, nothing emitted
        align();
        p0 = pulse_cnt; keys = K12;
        ticks(128);
        check("multi_no_pulse", pulse_cnt - p0, 0);
        check("multi_bcd", BCD_output, 4'b1111);
        keys = '0;
        ticks(128);

        // 4. bounce on '*', then held from the start of scan 6
        align();
        base = cyc; p0 = pulse_cnt; keys = KSTAR;
        for (int t = 1; t <= 80; t++) begin
            tick();
            if (t % 10 == 0) keys = keys ^ KSTAR;
        end
        ticks(64);
        check("bounce_quiet", pulse_cnt - p0, 0);
        tick();
        check("bounce_pulse_cycle", last_pulse_cyc - base, 145);
        check("bounce_code", BCD_output, 11);
        ticks(64);
        check("bounce_one_pulse", pulse_cnt - p0, 1);
        keys = '0;
        ticks(128);
        check("bounce_rel", BCD_output, 4'b1111);

        // 5a. '*' and '#' in the same snapshot
        align();
        base = cyc; p0 = pulse_cnt; keys = KSTAR | KHASH;
        ticks(65);
        check("combo_pulse_cycle", last_pulse_cyc - base, 65);
        check("combo_code", BCD_output, 13);
        ticks(64);
        check("combo_one_pulse", pulse_cnt - p0, 1);
        keys = '0;
        ticks(128);
        check("combo_rel_held", KEY_HELD, 0);

        // 5b. '*' accepted alone, '#' added later is ignored
        align();
        p0 = pulse_cnt; keys = KSTAR;
        ticks(80);
        check("star_code", BCD_output, 11);
        keys = keys | KHASH;
        ticks(128);
        check("star_hash_late_code", BCD_output, 11);
        check("star_hash_late_pulses", pulse_cnt - p0, 1);
        check("star_hash_late_held", KEY_HELD, 1);
        keys = '0;
        ticks(128);
        check("star_rel_pulses", pulse_cnt - p0, 1);
        check("star_rel_bcd", BCD_output, 4'b1111);

        // 6. reset while key 9 is held, mid-scan
        align();
        keys = K9;
        ticks(100);
        check("k9_held_pre_rst", KEY_HELD, 1);
        check("k9_code_pre_rst", BCD_output, 9);
        #2;
        RST = 1'b1;
        #1;
        check("midrst_row", ROW_OUT, 4'b1110);
        check("midrst_bcd", BCD_output, 4'b1111);
        check("midrst_held", KEY_HELD, 0);
        check("midrst_valid", KEY_VALID, 0);
        ticks(2);
        RST = 1'b0;
        cyc = 0;
        p0 = pulse_cnt;
        ticks(64);
        check("postrst_no_early", pulse_cnt - p0, 0);
        tick();
        check("postrst_pulse_cycle", last_pulse_cyc, 65);
        check("postrst_code", BCD_output, 9);
        keys = '0;
        ticks(128);
        check("postrst_rel", BCD_output, 4'b1111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/keypad_encoder.md
# keypad_encoder

- Scans the 4x3 elevator keypad matrix, debounces it, and encodes the pressed key into the 4-bit code consumed by the login/management FSM.
- Codes: digits 0–9, `*` = 11, `#` = 12, `*#` = 13.
- Produces one code per physical press: a level code plus a one-cycle strobe.
- Sits between the keypad pins and the management block's `BCD_input`.

## Interface

Parameters:
- `SCAN_DIV`, 4: clock cycles each row is driven. Must be ≥ 4.
- `DEBOUNCE_SCANS`, 3: consecutive identical full scans required after the first one before the key state is accepted. Must be ≥ 1.

Ports:
- `CLK`, input, 1: system clock, rising edge.
- `RST`, input, 1: asynchronous, active-high reset.
- `ROW_OUT`, output, 4: row drive, active-low, one-hot-low. Row 0 = `1 2 3`, row 1 = `4 5 6`, row 2 = `7 8 9`, row 3 = `* 0 #`.
- `COL_IN`, input, 3: column sense, active-low (pulled up externally). Column 0 is leftmost. Asynchronous to `CLK`.
- `BCD_output`, output, 4: encoded key while a debounced key is held; 4'b1111 otherwise.
- `KEY_VALID`, output, 1: one-cycle pulse when a new code is placed on `BCD_output`.
- `KEY_HELD`, output, 1: high while an accepted key is held (`PRESSED` state).

## Operation

Synchronizer:
- `COL_IN` passes through a 2-FF synchronizer before any use.

Row scan:
- A row counter 0..3 drives `ROW_OUT = ~(1 << row)`.
- Row advances every `SCAN_DIV` cycles and wraps 3→0.
- Synchronized columns are sampled on the last cycle of each row slot into a 12-bit snapshot at bits `[row*3 +: 3]` (1 = pressed).
- Scan end = the sample cycle of row 3.

Debounce:
- At each scan end, the new snapshot is compared with the previous snapshot.
- If equal, `stable_cnt` increments, saturating at `DEBOUNCE_SCANS`.
- If different, `stable_cnt` is cleared to 0.
- When `stable_cnt` reaches `DEBOUNCE_SCANS`, `deb_keys` is loaded with the snapshot.

Encode (combinational from `deb_keys`):
- Exactly one bit set → that key's code.
- Exactly `*` and `#` set, nothing else → 13.
- No bits set, or any other multi-key pattern → NONE.

FSM:
- **IDLE**:
  - Encoded value is a valid code → load `BCD_output`, pulse `KEY_VALID`, go to `PRESSED`.
  - Encoded value is NONE → stay in IDLE.
- **PRESSED**:
  - Encoded value is NONE with `deb_keys == 0` → `BCD_output` = 4'b1111, go to `IDLE`.
  - Any other change (e.g. `*` then `#` added, key rolled to another key) → no new pulse; `BCD_output` holds its value.
- There is no auto-repeat; the key must be released before the next press is accepted.
- `*#` is recognised only if both keys enter the same debounced snapshot. If `*` is accepted alone first, 11 is emitted and the later `#` is ignored until release.
- A multi-key pattern that is not `*#` is NONE but is not a release: in `PRESSED` it holds, in `IDLE` nothing is emitted.
- The downstream block is level-change sensitive. Returning to 4'b1111 on release guarantees that a repeated press of the same key produces a change.

## Timing

Reset values:
- `ROW_OUT` = 4'b1110, row counter = 0, slot counter = 0.
- Snapshot, previous snapshot, `deb_keys`, `stable_cnt` = 0.
- Synchronizer FFs = 3'b111.
- `BCD_output` = 4'b1111, `KEY_VALID` = 0, `KEY_HELD` = 0, FSM = `IDLE`.
- Reset asserted mid-scan or mid-press takes effect immediately. After release of `RST`, scanning restarts at row 0 with no pending pulse.

Scan timing:
- Full scan = `4*SCAN_DIV` cycles.
- Column settling + sync = `SCAN_DIV-1` cycles before the sample.

Press latency:
- A key stable from scan N is accepted at scan end N+`DEBOUNCE_SCANS`.
- `deb_keys` updates the cycle after that scan end.
- `BCD_output` / `KEY_VALID` / `KEY_HELD` update the cycle after `deb_keys`.

Release latency:
- Same debounce count, then `BCD_output` = 4'b1111 and `KEY_HELD` = 0 on the same cycle.

Pulse rules:
- `KEY_VALID` is high for exactly one cycle per accepted press.
- It coincides with the first cycle `BCD_output` shows the new code.

Bounce and widths:
- Bounce shorter than one scan resets `stable_cnt` and delays acceptance; it never produces a pulse.
- `stable_cnt` width is `$clog2(DEBOUNCE_SCANS+1)`, and it never wraps.

## Test plan

Defaults: `SCAN_DIV`=4, `DEBOUNCE_SCANS`=3, scan = 16 cycles.

1. **Reset.** Hold `RST`, `COL_IN`=3'b111 → `ROW_OUT`=4'b1110, `BCD_output`=4'b1111, `KEY_VALID`=0, `KEY_HELD`=0. After release, `ROW_OUT` cycles 1110→1101→1011→0111 every 4 cycles.
2. **Single press, key 5.** Model pulls col 1 low while row 1 is driven, held for 10 scans → exactly one `KEY_VALID` pulse, `BCD_output`=4'b0101, `KEY_HELD`=1. On release, after 4 scans → `BCD_output`=4'b1111, `KEY_HELD`=0.
3. **Repeat same key.** Press/release `0` twice → two pulses with code 0, 4'b1111 in between.
4. **Bounce.** Key `*` toggled every 10 cycles for 5 scans, then held → no pulse during bounce; one pulse with code 11 exactly 3 scan ends after the first fully stable scan (+2 cycles).
5. **`*#` combo.** Both pressed before the same scan → code 13 once. `*` held 5 scans, then `#` added → code 11 only, no second pulse until full release.
6. **Reset mid-press.** Assert `RST` while `KEY_HELD`=1 → outputs return to reset values immediately. With the key still held after `RST` release → a fresh pulse after the debounce latency.
